// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4-Lite slave in front of a word-organised SRAM.
// Independent read/write FSMs, byte strobes, OKAY/SLVERR responses.
//
// Ports (all on posedge ACLK, ARESET synchronous active-high):
//   ACLK, ARESET               clock and reset
//   ARADDR/ARVALID/ARREADY     read address channel
//   RDATA/RRESP/RVALID/RREADY  read data channel
//   AWADDR/AWVALID/AWREADY     write address channel
//   WDATA/WSTRB/WVALID/WREADY  write data channel
//   BRESP/BVALID/BREADY        write response channel
module axi_sram_slave #(
  parameter int                   ADDR_BITS = 32,
  parameter int                   DATA_BITS = 32,
  parameter int                   MEM_WORDS = 16384,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0,
  parameter int                   READ_LAT  = 1
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [ADDR_BITS-1:0]   ARADDR,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [DATA_BITS-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  input  logic [ADDR_BITS-1:0]   AWADDR,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATA_BITS-1:0]   WDATA,
  input  logic [DATA_BITS/8-1:0] WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY
);

  localparam int LANES = DATA_BITS / 8;
  localparam int IDX_W =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_BITS:0] LIMIT =
    (ADDR_BITS+1)'(MEM_WORDS * 4);
  localparam logic [2:0] CNT_INIT =
    3'(READ_LAT - 1);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COLLECT,
    W_RESP
  } w_state_t;

  logic [DATA_BITS-1:0] mem [MEM_WORDS];

  // Holds READY low for the cycle after reset is sampled,
  // so READY is never driven from ARESET combinationally.
  logic in_reset;

  always_ff @(posedge ACLK) begin
    in_reset <= ARESET;
  end

  // ---------------- read channel ----------------
  r_state_t             r_state;
  r_state_t             r_next;
  logic [2:0]           r_cnt;
  logic [2:0]           r_cnt_next;
  logic [ADDR_BITS-1:0] ar_addr;
  logic                 ar_load;
  logic                 r_load;
  logic [ADDR_BITS-1:0] r_off;
  logic                 r_hit;
  logic [IDX_W-1:0]     r_idx;

  assign r_off = ar_addr - BASE_ADDR;
  assign r_hit = {1'b0, r_off} < LIMIT;
  assign r_idx = r_off[IDX_W+1:2];

  assign ARREADY = (r_state == R_IDLE) && !in_reset;
  assign RVALID  = (r_state == R_RESP);

  always_comb begin
    r_next     = r_state;
    r_cnt_next = r_cnt;
    ar_load    = 1'b0;
    r_load     = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (ARVALID && ARREADY) begin
          ar_load    = 1'b1;
          r_cnt_next = CNT_INIT;
          r_next     = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt == 3'd0) begin
          r_load = 1'b1;
          r_next = R_RESP;
        end else begin
          r_cnt_next = r_cnt - 3'd1;
        end
      end
      R_RESP: begin
        if (RREADY) begin
          r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      ar_addr <= '0;
      RDATA   <= '0;
      RRESP   <= OKAY;
    end else begin
      r_state <= r_next;
      r_cnt   <= r_cnt_next;
      if (ar_load) begin
        ar_addr <= ARADDR;
      end
      // Sampled with the pre-edge array, so a write
      // committing on this same edge is not seen.
      if (r_load) begin
        RDATA <= r_hit ? mem[r_idx] : '0;
        RRESP <= r_hit ? OKAY : SLVERR;
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t             w_state;
  w_state_t             w_next;
  logic                 aw_got;
  logic                 aw_got_next;
  logic                 w_got;
  logic                 w_got_next;
  logic                 aw_load;
  logic                 wd_load;
  logic                 w_commit;
  logic [ADDR_BITS-1:0] aw_addr;
  logic [DATA_BITS-1:0] wdata_q;
  logic [LANES-1:0]     wstrb_q;
  logic [ADDR_BITS-1:0] w_off;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_open;

  assign w_off = aw_addr - BASE_ADDR;
  assign w_hit = {1'b0, w_off} < LIMIT;
  assign w_idx = w_off[IDX_W+1:2];

  assign w_open  = (w_state == W_IDLE) ||
                   (w_state == W_COLLECT);
  assign AWREADY = w_open && !aw_got && !in_reset;
  assign WREADY  = w_open && !w_got && !in_reset;
  assign BVALID  = (w_state == W_RESP);

  always_comb begin
    w_next      = w_state;
    aw_got_next = aw_got;
    w_got_next  = w_got;
    aw_load     = 1'b0;
    wd_load     = 1'b0;
    w_commit    = 1'b0;
    unique case (w_state)
      W_IDLE, W_COLLECT: begin
        if (aw_got && w_got) begin
          w_commit    = 1'b1;
          aw_got_next = 1'b0;
          w_got_next  = 1'b0;
          w_next      = W_RESP;
        end else begin
          if (AWVALID && AWREADY) begin
            aw_load     = 1'b1;
            aw_got_next = 1'b1;
          end
          if (WVALID && WREADY) begin
            wd_load    = 1'b1;
            w_got_next = 1'b1;
          end
          if (aw_got_next || w_got_next) begin
            w_next = W_COLLECT;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_addr <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      BRESP   <= OKAY;
    end else begin
      w_state <= w_next;
      aw_got  <= aw_got_next;
      w_got   <= w_got_next;
      if (aw_load) begin
        aw_addr <= AWADDR;
      end
      if (wd_load) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (w_commit) begin
        BRESP <= w_hit ? OKAY : SLVERR;
      end
    end
  end

  // SRAM array is never cleared by reset.
  always_ff @(posedge ACLK) begin
    if (w_commit && w_hit && !ARESET) begin
      for (int b = 0; b < LANES; b++) begin
        if (wstrb_q[b]) begin
          mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_r_hold: assert property (
    @(posedge ACLK) disable iff (ARESET)
    RVALID && !RREADY |=>
      RVALID && $stable(RDATA) && $stable(RRESP));

  a_b_hold: assert property (
    @(posedge ACLK) disable iff (ARESET)
    BVALID && !BREADY |=>
      BVALID && $stable(BRESP));
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bench for axi_sram_slave.
// Vector table for data/response, hand sequences for timing.
module tb_axi_sram_slave;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  logic [31:0] l3_araddr;
  logic        l3_arvalid;
  logic        l3_arready;
  logic [31:0] l3_rdata;
  logic [1:0]  l3_rresp;
  logic        l3_rvalid;
  logic        l3_rready;
  logic [31:0] l3_awaddr;
  logic        l3_awvalid;
  logic        l3_awready;
  logic [31:0] l3_wdata;
  logic [3:0]  l3_wstrb;
  logic        l3_wvalid;
  logic        l3_wready;
  logic [1:0]  l3_bresp;
  logic        l3_bvalid;
  logic        l3_bready;

  int n_chk;
  int n_fail;

  axi_sram_slave u_dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY)
  );

  axi_sram_slave #(
    .MEM_WORDS (16),
    .BASE_ADDR (32'h8000_0000),
    .READ_LAT  (3)
  ) u_lat3 (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .ARADDR  (l3_araddr),
    .ARVALID (l3_arvalid),
    .ARREADY (l3_arready),
    .RDATA   (l3_rdata),
    .RRESP   (l3_rresp),
    .RVALID  (l3_rvalid),
    .RREADY  (l3_rready),
    .AWADDR  (l3_awaddr),
    .AWVALID (l3_awvalid),
    .AWREADY (l3_awready),
    .WDATA   (l3_wdata),
    .WSTRB   (l3_wstrb),
    .WVALID  (l3_wvalid),
    .WREADY  (l3_wready),
    .BRESP   (l3_bresp),
    .BVALID  (l3_bvalid),
    .BREADY  (l3_bready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic do_read(
    input  logic [31:0] a,
    input  int          stall,
    output logic [31:0] d,
    output logic [1:0]  r,
    output int          lat,
    output bit          stable
  );
    int n;
    n = 0;
    stable = 1'b1;
    ARADDR = a;
    ARVALID = 1'b1;
    while (!ARREADY && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("arready", 32'(ARREADY), 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    lat = 0;
    while (!RVALID && lat < 20) begin
      @(posedge ACLK); #1;
      lat++;
    end
    d = RDATA;
    r = RRESP;
    repeat (stall) begin
      @(posedge ACLK); #1;
      if (!RVALID || RDATA !== d || RRESP !== r)
        stable = 1'b0;
    end
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    chk("rvalid_drop", 32'(RVALID), 32'd0);
  endtask

  task automatic do_write(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    input  int          aw_dly,
    input  int          w_dly,
    input  int          stall,
    output logic [1:0]  resp,
    output int          hs_cyc,
    output int          blat,
    output bit          early_b,
    output bit          stable
  );
    bit aw_done;
    bit w_done;
    bit hs_aw;
    bit hs_w;
    int cyc;
    aw_done = 1'b0;
    w_done = 1'b0;
    early_b = 1'b0;
    stable = 1'b1;
    hs_cyc = -1;
    cyc = 0;
    AWADDR = a;
    WDATA = d;
    WSTRB = s;
    while (!(aw_done && w_done) && cyc < 30) begin
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      if (BVALID) early_b = 1'b1;
      @(posedge ACLK); #1;
      if (hs_aw) aw_done = 1'b1;
      if (hs_w) w_done = 1'b1;
      if (aw_done && w_done) hs_cyc = cyc;
      cyc++;
    end
    AWVALID = 1'b0;
    WVALID = 1'b0;
    blat = 0;
    while (!BVALID && blat < 20) begin
      @(posedge ACLK); #1;
      blat++;
    end
    resp = BRESP;
    repeat (stall) begin
      @(posedge ACLK); #1;
      if (!BVALID || BRESP !== resp)
        stable = 1'b0;
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    chk("bvalid_drop", 32'(BVALID), 32'd0);
  endtask

  task automatic l3_read(input logic [31:0] a,
                         input logic [31:0] ed,
                         input logic [1:0]  er);
    int n;
    int lat;
    n = 0;
    l3_araddr = a;
    l3_arvalid = 1'b1;
    while (!l3_arready && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    @(posedge ACLK); #1;
    l3_arvalid = 1'b0;
    lat = 0;
    while (!l3_rvalid && lat < 20) begin
      @(posedge ACLK); #1;
      lat++;
    end
    chk("l3_lat", lat, 32'd3);
    chk("l3_rdata", l3_rdata, ed);
    chk("l3_rresp", 32'(l3_rresp), 32'(er));
    l3_rready = 1'b1;
    @(posedge ACLK); #1;
    l3_rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          hs;
    bit          eb;
    bit          st;
    int          n;

    n_chk = 0;
    n_fail = 0;

    tbl.push_back('{1, 32'h100, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h100, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF});
    tbl.push_back('{1, 32'h100, 32'h000000AA, 4'h1, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h100, 32'h0, 4'h0, 2'b00, 32'hDEADBEAA});
    tbl.push_back('{1, 32'h102, 32'h12340000, 4'hC, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h103, 32'h0, 4'h0, 2'b00, 32'h1234BEAA});
    tbl.push_back('{1, 32'h0, 32'h01020304, 4'hF, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h10000, 32'h0, 4'h0, 2'b10, 32'h0});
    tbl.push_back('{1, 32'h10000, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0});
    tbl.push_back('{0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h01020304});
    tbl.push_back('{1, 32'hFFFC, 32'h55AA55AA, 4'hF, 2'b00, 32'h0});
    tbl.push_back('{0, 32'hFFFC, 32'h0, 4'h0, 2'b00, 32'h55AA55AA});
    tbl.push_back('{1, 32'h200, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0});
    tbl.push_back('{1, 32'h200, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0});
    tbl.push_back('{0, 32'h200, 32'h0, 4'h0, 2'b00, 32'hCAFEF00D});

    ARESET = 1'b1;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    AWADDR = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0;
    l3_araddr = '0; l3_arvalid = 1'b0;
    l3_rready = 1'b0;
    l3_awaddr = '0; l3_awvalid = 1'b0;
    l3_wdata = '0; l3_wstrb = '0;
    l3_wvalid = 1'b0; l3_bready = 1'b0;

    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_rresp", 32'(RRESP), 32'd0);
    chk("rst_bresp", 32'(BRESP), 32'd0);

    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("idle_arready", 32'(ARREADY), 32'd1);
    chk("idle_awready", 32'(AWREADY), 32'd1);
    chk("idle_wready", 32'(WREADY), 32'd1);

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb,
                 0, 0, 0, r, hs, lat, eb, st);
        chk($sformatf("v%0d_bresp", i),
            32'(r), 32'(tbl[i].resp));
        chk($sformatf("v%0d_blat", i), lat, 32'd1);
      end else begin
        do_read(tbl[i].addr, 0, d, r, lat, st);
        chk($sformatf("v%0d_rresp", i),
            32'(r), 32'(tbl[i].resp));
        chk($sformatf("v%0d_rdata", i), d, tbl[i].rdata);
        chk($sformatf("v%0d_rlat", i), lat, 32'd1);
      end
    end

    // AW first, W three cycles later
    do_write(32'h400, 32'h11111111, 4'hF,
             0, 3, 0, r, hs, lat, eb, st);
    chk("awfirst_hs", hs, 32'd3);
    chk("awfirst_blat", lat, 32'd1);
    chk("awfirst_early", 32'(eb), 32'd0);
    // W first, AW two cycles later
    do_write(32'h404, 32'h22222222, 4'hF,
             2, 0, 0, r, hs, lat, eb, st);
    chk("wfirst_hs", hs, 32'd2);
    chk("wfirst_blat", lat, 32'd1);
    // AW and W together
    do_write(32'h408, 32'h33333333, 4'hF,
             0, 0, 0, r, hs, lat, eb, st);
    chk("same_hs", hs, 32'd0);
    chk("same_blat", lat, 32'd1);
    do_read(32'h400, 0, d, r, lat, st);
    chk("awfirst_data", d, 32'h11111111);
    do_read(32'h404, 0, d, r, lat, st);
    chk("wfirst_data", d, 32'h22222222);
    do_read(32'h408, 0, d, r, lat, st);
    chk("same_data", d, 32'h33333333);

    // BREADY / RREADY held low for 5 cycles
    do_write(32'h500, 32'h0BADF00D, 4'hF,
             0, 0, 5, r, hs, lat, eb, st);
    chk("bstall_stable", 32'(st), 32'd1);
    chk("bstall_bresp", 32'(r), 32'd0);
    do_read(32'h500, 5, d, r, lat, st);
    chk("rstall_stable", 32'(st), 32'd1);
    chk("rstall_rdata", d, 32'h0BADF00D);
    do_write(32'h20000, 32'h0, 4'hF,
             0, 0, 5, r, hs, lat, eb, st);
    chk("bstall_err_stable", 32'(st), 32'd1);
    chk("bstall_err_bresp", 32'(r), 32'd2);

    // READ_LAT=3 instance
    l3_awaddr = 32'h8000_0008;
    l3_wdata = 32'hA5A5A5A5;
    l3_wstrb = 4'hF;
    l3_awvalid = 1'b1;
    l3_wvalid = 1'b1;
    @(posedge ACLK); #1;
    l3_awvalid = 1'b0;
    l3_wvalid = 1'b0;
    n = 0;
    while (!l3_bvalid && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("l3_blat", n, 32'd1);
    chk("l3_bresp", 32'(l3_bresp), 32'd0);
    l3_bready = 1'b1;
    @(posedge ACLK); #1;
    l3_bready = 1'b0;
    l3_read(32'h8000_0008, 32'hA5A5A5A5, 2'b00);
    l3_read(32'h7FFF_FFFC, 32'h0, 2'b10);
    l3_read(32'h8000_0040, 32'h0, 2'b10);

    // Reset while read in R_WAIT and write in W_COLLECT
    ARADDR = 32'h100;
    ARVALID = 1'b1;
    AWADDR = 32'h100;
    AWVALID = 1'b1;
    chk("pre_rst_ready",
        32'({ARREADY, AWREADY}), 32'd3);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    AWVALID = 1'b0;
    chk("collect_wready", 32'(WREADY), 32'd1);
    chk("wait_arready", 32'(ARREADY), 32'd0);
    ARESET = 1'b1;
    WDATA = 32'hFFFFFFFF;
    WSTRB = 4'hF;
    WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    chk("mid_rst_rvalid", 32'(RVALID), 32'd0);
    chk("mid_rst_bvalid", 32'(BVALID), 32'd0);
    chk("mid_rst_arready", 32'(ARREADY), 32'd0);
    chk("mid_rst_awready", 32'(AWREADY), 32'd0);
    chk("mid_rst_wready", 32'(WREADY), 32'd0);
    chk("mid_rst_rdata", RDATA, 32'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("post_rst_ready",
        32'({ARREADY, AWREADY, WREADY}), 32'd7);
    do_read(32'h100, 0, d, r, lat, st);
    chk("post_rst_mem100", d, 32'h1234BEAA);
    do_read(32'h0, 0, d, r, lat, st);
    chk("post_rst_mem0", d, 32'h01020304);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
